// File: rtl/if_stage.sv
// Instruction fetch stage: holds the PC, fetches one word per req/ack
// handshake, and hands it to decode over valid/ready with branch redirect.
module if_stage #(
  parameter int unsigned IW          = 8,
  parameter int unsigned IMW         = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  output logic [IMW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_rdata,
  output logic [IW-1:0]  instruction,
  output logic [IMW-1:0] instr_pc,
  output logic           instr_valid,
  input  logic           id_ready,
  input  logic           branch_taken,
  input  logic [IMW-1:0] branch_target,
  output logic           fetch_err
);

  localparam int unsigned CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HAVE  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]     state, state_nx;
  logic [IMW-1:0] pc, pc_nx;
  logic [CW-1:0]  wait_cnt, wait_cnt_nx;
  logic [IW-1:0]  instruction_nx;
  logic [IMW-1:0] instr_pc_nx;

  assign imem_addr = pc;

  // Next-state and datapath updates
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    wait_cnt_nx    = wait_cnt;
    instruction_nx = instruction;
    instr_pc_nx    = instr_pc;
    case (state)
      S_START: begin
        state_nx    = S_FETCH;
        wait_cnt_nx = '0;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instruction_nx = imem_rdata;
          instr_pc_nx    = pc;
          pc_nx          = pc + IMW'(1);
          state_nx       = S_HAVE;
        end else if (wait_cnt == CW'(ACK_TIMEOUT)) begin
          state_nx = S_ERR;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      S_HAVE: begin
        // pc already points past the held instruction; a taken branch overrides it
        if (id_ready) begin
          state_nx    = S_FETCH;
          wait_cnt_nx = '0;
          if (branch_taken) pc_nx = branch_target;
        end
      end
      S_ERR: begin
        state_nx = S_ERR;
      end
      default: begin
        state_nx = S_START;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_START;
      pc          <= '0;
      wait_cnt    <= '0;
      instruction <= '0;
      instr_pc    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      wait_cnt    <= wait_cnt_nx;
      instruction <= instruction_nx;
      instr_pc    <= instr_pc_nx;
      imem_req    <= (state_nx == S_FETCH);
      instr_valid <= (state_nx == S_HAVE);
      fetch_err   <= (state_nx == S_ERR);
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed transaction table, timeout/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_if_stage;

  localparam int unsigned IW  = 8;
  localparam int unsigned IMW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           imem_req;
  logic [IMW-1:0] imem_addr;
  logic           imem_ack;
  logic [IW-1:0]  imem_rdata;
  logic [IW-1:0]  instruction;
  logic [IMW-1:0] instr_pc;
  logic           instr_valid;
  logic           id_ready;
  logic           branch_taken;
  logic [IMW-1:0] branch_target;
  logic           fetch_err;

  int checks = 0;
  int errors = 0;

  if_stage #(.IW(IW), .IMW(IMW), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .id_ready(id_ready), .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IMW-1:0] addr;
    logic [IW-1:0]  rdata;
    int             ack_wait;
    int             rdy_wait;
    logic           br;
    logic [IMW-1:0] tgt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    logic [IMW-1:0] nxt;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(v.addr));
    for (int i = 0; i < v.ack_wait; i++) begin
      imem_ack = 1'b0;
      imem_rdata = IW'($urandom);
      step();
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", 32'(imem_addr), 32'(v.addr));
    end
    imem_ack = 1'b1;
    imem_rdata = v.rdata;
    step();
    imem_ack = 1'b0;
    imem_rdata = IW'($urandom);
    chk("valid_after_ack", 32'(instr_valid), 32'd1);
    chk("req_drop_after_ack", 32'(imem_req), 32'd0);
    chk("instruction", 32'(instruction), 32'(v.rdata));
    chk("instr_pc", 32'(instr_pc), 32'(v.addr));
    for (int i = 0; i < v.rdy_wait; i++) begin
      id_ready = 1'b0;
      branch_taken = 1'b1;
      branch_target = IMW'($urandom);
      imem_ack = 1'b1;
      step();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", 32'(instruction), 32'(v.rdata));
      chk("stall_no_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    id_ready = 1'b1;
    branch_taken = v.br;
    branch_target = v.tgt;
    step();
    id_ready = 1'b0;
    branch_taken = 1'b0;
    nxt = v.br ? v.tgt : v.addr + IMW'(1);
    chk("valid_drop", 32'(instr_valid), 32'd0);
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("next_addr", 32'(imem_addr), 32'(nxt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_ipc", 32'(instr_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("start_idle", 32'(imem_req), 32'd0);
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
  endtask

  // Random-run model state
  logic           p_req, p_ack, p_valid, p_ready, p_br;
  logic [IMW-1:0] p_addr, p_tgt, p_ipc, exp_addr;
  logic [IW-1:0]  p_rdata, p_instr;
  int             lat;

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    id_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;

    vecs[0] = '{4'h0, 8'h10, 0,  0, 1'b0, 4'h0};
    vecs[1] = '{4'h1, 8'h21, 0,  0, 1'b0, 4'h0};
    vecs[2] = '{4'h2, 8'h32, 0,  0, 1'b1, 4'hA};
    vecs[3] = '{4'hA, 8'hA5, 0,  4, 1'b0, 4'h0};
    vecs[4] = '{4'hB, 8'h4C, 2,  0, 1'b1, 4'hF};
    vecs[5] = '{4'hF, 8'h5D, 0,  0, 1'b0, 4'h0};
    vecs[6] = '{4'h0, 8'h6E, 15, 0, 1'b0, 4'h0};
    vecs[7] = '{4'h1, 8'h7F, 1,  1, 1'b1, 4'h3};

    #7;
    do_reset();
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // No ack for 16 FETCH cycles: error is terminal
    for (int i = 0; i < 15; i++) begin
      imem_ack = 1'b0;
      step();
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_no_err", 32'(fetch_err), 32'd0);
    end
    step();
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req_drop", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    id_ready = 1'b1;
    repeat (3) step();
    imem_ack = 1'b0;
    id_ready = 1'b0;
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_no_req", 32'(imem_req), 32'd0);
    chk("err_no_valid", 32'(instr_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_clears_err", 32'(fetch_err), 32'd0);

    // Reset mid-FETCH
    do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_fetch", 32'(imem_req), 32'd0);

    // Reset mid-HAVE
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = 8'hC3;
    step();
    imem_ack = 1'b0;
    chk("have_valid", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_have_valid", 32'(instr_valid), 32'd0);
    chk("rst_mid_have_instr", 32'(instruction), 32'd0);

    // Randomized run against a transaction-level model
    do_reset();
    exp_addr = '0;
    p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_br = 1'b0;
    p_addr = '0; p_tgt = '0; p_ipc = '0; p_rdata = '0; p_instr = '0;
    lat = 0;
    for (int c = 0; c < 1500; c++) begin
      chk("rnd_no_err", 32'(fetch_err), 32'd0);
      if (p_req && p_ack) begin
        chk("rnd_valid", 32'(instr_valid), 32'd1);
        chk("rnd_req_off", 32'(imem_req), 32'd0);
        chk("rnd_instr", 32'(instruction), 32'(p_rdata));
        chk("rnd_ipc", 32'(instr_pc), 32'(p_addr));
      end else if (p_valid && p_ready) begin
        exp_addr = p_br ? p_tgt : p_ipc + IMW'(1);
        chk("rnd_valid_off", 32'(instr_valid), 32'd0);
        chk("rnd_refetch", 32'(imem_req), 32'd1);
      end else if (p_valid) begin
        chk("rnd_hold_valid", 32'(instr_valid), 32'd1);
        chk("rnd_hold_instr", 32'(instruction), 32'(p_instr));
        chk("rnd_hold_noreq", 32'(imem_req), 32'd0);
      end else if (p_req) begin
        chk("rnd_wait_req", 32'(imem_req), 32'd1);
        chk("rnd_wait_novalid", 32'(instr_valid), 32'd0);
      end
      if (imem_req) chk("rnd_addr", 32'(imem_addr), 32'(exp_addr));

      if (imem_req) begin
        if (!p_req) lat = int'($urandom_range(0, 5));
        imem_ack = (lat == 0);
        lat = lat - 1;
      end else begin
        imem_ack = ($urandom_range(0, 3) == 0);
      end
      imem_rdata = IW'($urandom);
      id_ready = 1'($urandom);
      branch_taken = ($urandom_range(0, 2) == 0);
      branch_target = IMW'($urandom);

      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_rdata = imem_rdata;
      p_valid = instr_valid; p_ready = id_ready; p_br = branch_taken;
      p_tgt = branch_target; p_ipc = instr_pc; p_instr = instruction;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
